// File: rtl/apu_pkg.sv
// apu_pkg: shared constants for the APU sequencer blocks.
//   - default geometry of the song-ROM arbiter (channels, note index, word width)
//   - bit positions of the fields inside a 16-bit note word
package apu_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 16;

  // Note word layout: [14:11] instrument, [10:6] length, [5:0] note.
  localparam int NOTE_LSB = 0;
  localparam int NOTE_W   = 6;
  localparam int LEN_LSB  = 6;
  localparam int LEN_W    = 5;
  localparam int INST_LSB = 11;
  localparam int INST_W   = 4;

  typedef struct packed {
    logic                  rsvd;
    logic [INST_W-1:0]     instrument;
    logic [LEN_W-1:0]      length;
    logic [NOTE_W-1:0]     note;
  } note_word_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational round-robin pick.
//   pend_i    : pending request vector
//   ptr_i     : last-granted channel; search starts at ptr_i+1 (wrapping)
//   gnt_o     : one-hot grant (zero when nothing pending)
//   gnt_id_o  : index of the granted channel
//   gnt_vld_o : a grant was made
module rr_priority_picker #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] pend_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [CH_W-1:0]   gnt_id_o,
  output logic              gnt_vld_o
);

  logic [CH_W-1:0] idx;
  logic            found;

  // NUM_CH is a power of two, so the CH_W-bit add wraps modulo NUM_CH;
  // the last iteration (i == NUM_CH) lands back on ptr_i itself.
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    idx      = '0;
    found    = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = ptr_i + CH_W'(i);
      if (!found && pend_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
      end
    end
  end

  assign gnt_vld_o = |pend_i;

endmodule

// File: rtl/note_rom_arbiter.sv
// note_rom_arbiter: shares one song ROM between NUM_CH sequencer channels.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_req_stb      : per-channel one-cycle read strobe
//   i_req_addr     : packed per-channel note indices
//   o_rom_en       : ROM read enable
//   o_rom_addr     : {channel id, note index}
//   i_rom_data     : ROM data, one cycle after o_rom_en
//   o_valid        : one-hot per-channel data-valid pulse
//   o_data         : returned note word (held between pulses)
module note_rom_arbiter
  import apu_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_CH-1:0]        i_req_stb,
  input  logic [NUM_CH*ADDR_W-1:0] i_req_addr,
  output logic                     o_rom_en,
  output logic [CH_W+ADDR_W-1:0]   o_rom_addr,
  input  logic [DATA_W-1:0]        i_rom_data,
  output logic [NUM_CH-1:0]        o_valid,
  output logic [DATA_W-1:0]        o_data
);

  localparam logic [NUM_CH-1:0] ONE_CH = {{(NUM_CH-1){1'b0}}, 1'b1};

  logic [NUM_CH-1:0]      pend_q, pend_d;
  logic [ADDR_W-1:0]      addr_q [NUM_CH];
  logic [ADDR_W-1:0]      addr_d [NUM_CH];
  logic [CH_W-1:0]        ptr_q;
  logic                   rom_en_q;
  logic [CH_W+ADDR_W-1:0] rom_addr_q;
  logic                   tag1_vld_q, tag2_vld_q;
  logic [CH_W-1:0]        tag1_q, tag2_q;
  logic [NUM_CH-1:0]      valid_q;
  logic [DATA_W-1:0]      data_q;

  logic [NUM_CH-1:0]      gnt;
  logic [CH_W-1:0]        gnt_id;
  logic                   gnt_vld;

  rr_priority_picker #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_picker (
    .pend_i    (pend_q),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id),
    .gnt_vld_o (gnt_vld)
  );

  // A strobe wins over the grant clear: the granted read uses the old
  // captured address while the channel stays pending with the new one.
  always_comb begin
    pend_d = (pend_q & ~gnt) | i_req_stb;
    for (int k = 0; k < NUM_CH; k++) begin
      addr_d[k] = i_req_stb[k] ? i_req_addr[k*ADDR_W +: ADDR_W] : addr_q[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q     <= '0;
      for (int k = 0; k < NUM_CH; k++) addr_q[k] <= '0;
      ptr_q      <= CH_W'(NUM_CH - 1);
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      tag1_vld_q <= 1'b0;
      tag1_q     <= '0;
      tag2_vld_q <= 1'b0;
      tag2_q     <= '0;
      valid_q    <= '0;
      data_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      rom_en_q   <= gnt_vld;
      if (gnt_vld) begin
        rom_addr_q <= {gnt_id, addr_q[gnt_id]};
        ptr_q      <= gnt_id;
      end
      // Stage 1 aligns with o_rom_en, stage 2 with i_rom_data.
      tag1_vld_q <= gnt_vld;
      tag1_q     <= gnt_id;
      tag2_vld_q <= tag1_vld_q;
      tag2_q     <= tag1_q;
      valid_q    <= tag2_vld_q ? (ONE_CH << tag2_q) : '0;
      if (tag2_vld_q) data_q <= i_rom_data;
    end
  end

  assign o_rom_en   = rom_en_q;
  assign o_rom_addr = rom_addr_q;
  assign o_valid    = valid_q;
  assign o_data     = data_q;

endmodule

// File: tb/tb_note_rom_arbiter.sv
module tb_note_rom_arbiter;

  localparam int NCH = 4;
  localparam int AW  = 5;
  localparam int DW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    stb;
  logic [NCH*AW-1:0] req_addr;
  logic              rom_en;
  logic [AW+1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic [NCH-1:0]    valid;
  logic [DW-1:0]     data;

  always #5 clk = ~clk;

  note_rom_arbiter dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_stb  (stb),
    .i_req_addr (req_addr),
    .o_rom_en   (rom_en),
    .o_rom_addr (rom_addr),
    .i_rom_data (rom_data),
    .o_valid    (valid),
    .o_data     (data)
  );

  // ROM: data = A000 | addr one cycle after enable; junk otherwise.
  always @(posedge clk)
    rom_data <= rom_en ? (16'hA000 | {9'd0, rom_addr}) : 16'h5A5A;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: pending set + round-robin pointer, reads tracked as a
  // list of outstanding transactions with the edge at which they complete.
  typedef struct {int ch; int a; int due;} rd_t;
  bit  m_pend [NCH];
  int  m_addr [NCH];
  int  m_last;
  int  m_en, m_raddr, m_valid, m_data;
  int  edge_n = 0;
  rd_t inflight [$];

  task automatic model_edge(input bit r, input logic [NCH-1:0] s, input logic [NCH*AW-1:0] a);
    int  g;
    bit  found;
    if (r) begin
      for (int c = 0; c < NCH; c++) begin m_pend[c] = 0; m_addr[c] = 0; end
      m_last = NCH - 1; m_en = 0; m_raddr = 0; m_valid = 0; m_data = 0;
      inflight.delete();
    end else begin
      m_valid = 0;
      if (inflight.size() > 0 && inflight[0].due == edge_n) begin
        m_valid = 1 << inflight[0].ch;
        m_data  = 'hA000 | inflight[0].a;
        void'(inflight.pop_front());
      end
      found = 0; g = 0;
      for (int k = 1; k <= NCH; k++)
        if (!found && m_pend[(m_last + k) % NCH]) begin found = 1; g = (m_last + k) % NCH; end
      m_en = found;
      if (found) begin
        m_raddr = g * (1 << AW) + m_addr[g];
        m_pend[g] = 0;
        m_last = g;
        inflight.push_back('{g, m_raddr, edge_n + 2});
      end
      for (int c = 0; c < NCH; c++)
        if (s[c]) begin m_pend[c] = 1; m_addr[c] = int'(a[c*AW +: AW]); end
    end
    edge_n++;
  endtask

  // Drive inputs for one cycle, clock it, then check outputs 1ns later.
  task automatic step(input bit r, input logic [NCH-1:0] s, input logic [NCH*AW-1:0] a);
    rst = r; stb = s; req_addr = a;
    @(posedge clk);
    model_edge(r, s, a);
    #1;
    chk("rom_en", 32'(rom_en), m_en);
    chk("rom_addr", 32'(rom_addr), m_raddr);
    chk("valid", 32'(valid), m_valid);
    chk("data", 32'(data), m_data);
  endtask

  function automatic logic [NCH*AW-1:0] pack1(input int ch, input int ad);
    logic [NCH*AW-1:0] v;
    v = '0;
    v[ch*AW +: AW] = AW'(ad);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n1, last_d, idx;
    bit seen;
    logic [NCH*AW-1:0] a;

    step(1, '0, '0);
    step(1, '0, '0);
    chk("rst_en", 32'(rom_en), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data), 0);

    // ch2 addr 7 in cycle C: read at C+2, data valid at C+4
    step(0, '0, '0);
    step(0, 4'b0100, pack1(2, 7));
    step(0, '0, '0);
    chk("t31_en", 32'(rom_en), 1);
    chk("t31_addr", 32'(rom_addr), 32'h47);
    step(0, '0, '0);
    step(0, '0, '0);
    chk("t31_valid", 32'(valid), 32'b0100);
    chk("t31_data", 32'(data), 32'hA047);

    // all channels at once: grants 0..3, valids on consecutive cycles
    step(1, '0, '0);
    a = pack1(0, 3) | pack1(1, 3) | pack1(2, 3) | pack1(3, 3);
    step(0, 4'b1111, a);
    for (int i = 0; i < 6; i++) begin
      step(0, '0, '0);
      if (i < 4) chk("t32_addr", 32'(rom_addr), i * 32 + 3);
      if (i >= 2) chk("t32_valid", 32'(valid), 1 << (i - 2));
    end

    // ch1 re-strobed while waiting behind ch0: one read with newest address
    step(1, '0, '0);
    step(0, 4'b0011, pack1(1, 5));
    step(0, 4'b0010, pack1(1, 9));
    n1 = 0; last_d = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, '0, '0);
      if (valid == 4'b0010) begin n1++; last_d = int'(data); end
    end
    chk("t33_reads", n1, 1);
    chk("t33_data", last_d, 32'hA029);

    // ch0 hammering, ch3 once: ch3 granted within NCH cycles
    step(1, '0, '0);
    seen = 0; idx = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, (i == 0) ? 4'b1001 : 4'b0001, pack1(3, 11));
      if (!seen && rom_en && rom_addr[AW+1:AW] == 2'd3) begin seen = 1; idx = i; end
    end
    chk("t34_seen", seen, 1);
    chk("t34_within", idx <= NCH, 1);

    // reset one cycle after o_rom_en: read discarded, pending cleared
    step(1, '0, '0);
    step(0, 4'b1100, pack1(2, 1) | pack1(3, 4));
    step(0, '0, '0);
    chk("t35_en", 32'(rom_en), 1);
    step(1, 4'b1000, pack1(3, 6));
    n1 = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, '0, '0);
      if (valid != 0 || rom_en) n1++;
    end
    chk("t35_quiet", n1, 0);
    step(0, 4'b0011, pack1(0, 2) | pack1(1, 2));
    step(0, '0, '0);
    chk("t35_first", 32'(rom_addr), 32'h02);

    // strobe coinciding with grant: old address read, then new
    step(1, '0, '0);
    step(0, 4'b0010, pack1(1, 2));
    step(0, 4'b0010, pack1(1, 6));
    chk("t36_addr_old", 32'(rom_addr), 32'h22);
    step(0, '0, '0);
    chk("t36_addr_new", 32'(rom_addr), 32'h26);
    step(0, '0, '0);
    chk("t36_data_old", 32'(data), 32'hA022);
    step(0, '0, '0);
    chk("t36_data_new", 32'(data), 32'hA026);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 59) == 0, NCH'($urandom & $urandom), (NCH*AW)'($urandom));
    for (int i = 0; i < 6; i++) step(0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
